// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_unit
// Purpose  : Registered ALU execute stage. An arithmetic/logic unit feeds a
//            one-position shifter. The shifted result, the unit carry-out and
//            a zero flag are captured on every rising clock edge. The unit
//            accepts one operation per cycle and has no handshake.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset (y=0, cout=0, zf=1)
//            a    - operand A                       [SIZE-1:0]
//            b    - operand B                       [SIZE-1:0]
//            cin  - carry-in to the arithmetic unit
//            sel  - [5:4] shift, [3] 1=arith/0=logic, [2:0] opcode
//            y    - registered shifted result       [SIZE-1:0]
//            cout - registered arithmetic carry-out (0 for logic ops)
//            zf   - registered zero flag of y
// Revision : 1.0 - initial release
// ============================================================================
module alu_unit #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    input  logic [5:0]      sel,
    output logic [SIZE-1:0] y,
    output logic            cout,
    output logic            zf
);

    localparam logic [1:0] c_SH_PASS  = 2'b00;
    localparam logic [1:0] c_SH_RIGHT = 2'b01;
    localparam logic [1:0] c_SH_LEFT  = 2'b10;

    logic [SIZE-1:0] w_opa;
    logic [SIZE-1:0] w_opb;
    logic [SIZE:0]   w_sum;
    logic [SIZE-1:0] w_logic;
    logic [SIZE-1:0] w_unit;
    logic            w_carry;
    logic [SIZE-1:0] w_shift;

    logic [SIZE-1:0] r_y;
    logic            r_cout;
    logic            r_zf;

    // Every arithmetic op is a single adder fed by a selected pair of
    // operands plus cin; only the operand selection varies by opcode.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        case (sel[2:0])
            3'b000: begin w_opa = a;  w_opb = '0; end
            3'b001: begin w_opa = a;  w_opb = b;  end
            3'b010: begin w_opa = a;  w_opb = ~b; end
            3'b011: begin w_opa = a;  w_opb = '1; end
            3'b100: begin w_opa = '0; w_opb = b;  end
            3'b101: begin w_opa = ~a; w_opb = b;  end
            3'b110: begin w_opa = a;  w_opb = a;  end
            default: begin w_opa = '0; w_opb = '0; end
        endcase
    end

    assign w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {{SIZE{1'b0}}, cin};

    always_comb begin
        w_logic = '0;
        case (sel[2:0])
            3'b000:  w_logic = a & b;
            3'b001:  w_logic = a | b;
            3'b010:  w_logic = a ^ b;
            3'b011:  w_logic = ~a;
            3'b100:  w_logic = ~(a & b);
            3'b101:  w_logic = ~(a | b);
            3'b110:  w_logic = ~(a ^ b);
            default: w_logic = b;
        endcase
    end

    // Logic ops never produce a carry, whatever cin is.
    assign w_unit  = sel[3] ? w_sum[SIZE-1:0] : w_logic;
    assign w_carry = sel[3] ? w_sum[SIZE]     : 1'b0;

    always_comb begin
        w_shift = '0;
        case (sel[5:4])
            c_SH_PASS:  w_shift = w_unit;
            c_SH_RIGHT: w_shift = {1'b0, w_unit[SIZE-1:1]};
            c_SH_LEFT:  w_shift = {w_unit[SIZE-2:0], 1'b0};
            default:    w_shift = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y    <= '0;
            r_cout <= 1'b0;
            r_zf   <= 1'b1;
        end else begin
            r_y    <= w_shift;
            r_cout <= w_carry;
            r_zf   <= (w_shift == '0);
        end
    end

    assign y    = r_y;
    assign cout = r_cout;
    assign zf   = r_zf;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_unit
// Purpose  : Scoreboard bench for alu_unit. The driver pushes the expected
//            result of every issued operation into a queue; a monitor pops
//            and compares after each rising edge. Expected values come from
//            an integer-arithmetic reference model of the operation table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

    localparam int SIZE = 8;
    localparam int MOD  = 1 << SIZE;

    typedef struct {
        int          id;
        logic [7:0]  y;
        logic        c;
        logic        z;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
    logic [5:0]      sel;
    logic [SIZE-1:0] y;
    logic            cout;
    logic            zf;

    exp_t q[$];
    int   total;
    int   bad;
    int   next_id;

    alu_unit #(.SIZE(SIZE)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sel  (sel),
        .y    (y),
        .cout (cout),
        .zf   (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (op %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
        end
    endtask

    // Reference model: sums in plain integers, carry = sum reached 2^SIZE.
    function automatic void model(input int ua, input int ub, input int ci,
                                  input logic [5:0] s, output logic [7:0] ry,
                                  output logic rc, output logic rz);
        int sum;
        int r;
        int m;
        m   = MOD - 1;
        sum = 0;
        r   = 0;
        rc  = 1'b0;
        if (s[3]) begin
            case (s[2:0])
                3'd0: sum = ua + ci;
                3'd1: sum = ua + ub + ci;
                3'd2: sum = ua + (m - ub) + ci;
                3'd3: sum = ua + m + ci;
                3'd4: sum = ub + ci;
                3'd5: sum = (m - ua) + ub + ci;
                3'd6: sum = 2 * ua + ci;
                default: sum = ci;
            endcase
            r  = sum % MOD;
            rc = (sum >= MOD);
        end else begin
            case (s[2:0])
                3'd0: r = ua & ub;
                3'd1: r = ua | ub;
                3'd2: r = ua ^ ub;
                3'd3: r = m - ua;
                3'd4: r = m - (ua & ub);
                3'd5: r = m - (ua | ub);
                3'd6: r = m - (ua ^ ub);
                default: r = ub;
            endcase
        end
        case (s[5:4])
            2'd0: r = r;
            2'd1: r = r / 2;
            2'd2: r = (r * 2) % MOD;
            default: r = 0;
        endcase
        ry = r[7:0];
        rz = (r == 0);
    endfunction

    task automatic issue(input int ia, input int ib, input int ic, input logic [5:0] s);
        exp_t e;
        @(negedge clk);
        a   = ia[7:0];
        b   = ib[7:0];
        cin = ic[0];
        sel = s;
        e.id = next_id;
        next_id++;
        model(ia, ib, ic, s, e.y, e.c, e.z);
        q.push_back(e);
    endtask

    // Monitor: one result per clock edge while expectations are pending.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && q.size() > 0) begin
            e = q.pop_front();
            chk("y",    e.id, 32'(y),    32'(e.y));
            chk("cout", e.id, 32'(cout), 32'(e.c));
            chk("zf",   e.id, 32'(zf),   32'(e.z));
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        total   = 0;
        bad     = 0;
        next_id = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        sel = '0;
        #3;
        chk("reset_y",    -1, 32'(y),    32'h00);
        chk("reset_cout", -1, 32'(cout), 32'h0);
        chk("reset_zf",   -1, 32'(zf),   32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the operation table
        issue(45, 34, 1, 6'b10_1_010);   // 0x0B << 1 = 0x16, cout=1
        issue(45, 34, 1, 6'b10_0_010);   // 0x0F << 1 = 0x1E
        issue(45, 34, 1, 6'b10_0_101);   // NOR 0xD0 << 1 = 0xA0
        issue(45, 34, 1, 6'b00_0_101);   // 0xD0
        issue(45, 34, 1, 6'b11_0_101);   // 0x00, zf=1
        issue(34, 45, 1, 6'b00_1_010);   // 0xF5, borrow
        issue(34, 45, 1, 6'b01_1_001);   // 80 >> 1 = 0x28
        issue(255, 34, 1, 6'b00_1_000);  // wrap to 0, cout=1
        issue(0, 0, 0, 6'b00_1_011);     // 0 - 1 = 0xFF, no carry
        issue(128, 0, 0, 6'b00_1_110);   // 0x80 + 0x80 wraps, cout=1

        // Randomized operations
        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 1), 6'($urandom_range(0, 63)));

        // Leave a nonzero result registered, then reset mid-cycle.
        issue(45, 34, 1, 6'b10_1_010);
        @(negedge clk);
        a   = 8'hFF;
        b   = 8'h00;
        cin = 1'b0;
        sel = 6'b00_0_111;              // would give b=0 but is discarded
        #1;
        if (q.size() != 0) chk("drain", -1, 32'(q.size()), 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_y",    -2, 32'(y),    32'h00);
        chk("async_rst_cout", -2, 32'(cout), 32'h0);
        chk("async_rst_zf",   -2, 32'(zf),   32'h1);
        a   = 8'h12;
        b   = 8'h34;
        sel = 6'b00_0_001;
        @(posedge clk);
        #1;
        chk("held_rst_y",  -3, 32'(y),  32'h00);
        chk("held_rst_zf", -3, 32'(zf), 32'h1);

        // Release: first edge loads the inputs present at that edge.
        @(negedge clk);
        rst = 1'b0;
        begin
            exp_t e;
            e.id = next_id;
            next_id++;
            model(32'h12, 32'h34, 0, 6'b00_0_001, e.y, e.c, e.z);
            q.push_back(e);
        end
        issue(200, 100, 1, 6'b00_1_001);

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) chk("drain_end", -1, 32'(q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
